// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types, default phase timings and helpers for the
//               intersection phase scheduler family.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  localparam int NUM_APPROACH  = 4;
  localparam int DEF_GREEN_MIN = 4;
  localparam int DEF_GREEN_MAX = 14;
  localparam int DEF_YELLOW_T  = 4;
  localparam int DEF_ALLRED_T  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } phase_state_t;

  function automatic logic [NUM_APPROACH-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker with emergency preempt.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import traffic_pkg::*;
(
  input  logic [NUM_APPROACH-1:0] i_req,
  input  logic [1:0]              i_last,
  input  logic                    i_preempt,
  input  logic [1:0]              i_preempt_id,
  output logic [1:0]              o_winner,
  output logic                    o_valid
);

  logic [1:0] w_idx;

  always_comb begin
    o_winner = i_last;
    o_valid  = 1'b0;
    w_idx    = '0;
    if (i_preempt) begin
      o_winner = i_preempt_id;
      o_valid  = 1'b1;
    end else begin
      // Search starts just after the last-served approach, so it ranks lowest.
      for (int i = 1; i <= NUM_APPROACH; i++) begin
        w_idx = i_last + 2'(i);
        if (!o_valid && i_req[w_idx]) begin
          o_winner = w_idx;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Four-approach GREEN/YELLOW/ALL_RED sequencer with RR + preempt.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [NUM_APPROACH-1:0] req,
  input  logic                    preempt,
  input  logic [1:0]              preempt_id,
  output logic [NUM_APPROACH-1:0] grant,
  output logic [NUM_APPROACH-1:0] yellow,
  output logic                    all_red,
  output logic                    phase_done
);

  localparam int TW = $clog2(max4(GREEN_MIN, GREEN_MAX, YELLOW_T, ALLRED_T)) + 1;

  localparam logic [TW-1:0] c_GMIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] c_GMAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] c_Y_LAST    = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] c_AR_LAST   = TW'(ALLRED_T - 1);

  phase_state_t            r_state, w_state_nxt;
  logic [1:0]              r_cur, w_cur_nxt;
  logic [1:0]              r_last, w_last_nxt;
  logic [TW-1:0]           r_timer, w_timer_nxt;
  logic [NUM_APPROACH-1:0] r_grant, w_grant_nxt;
  logic [NUM_APPROACH-1:0] r_yellow, w_yellow_nxt;
  logic                    r_all_red, w_all_red_nxt;
  logic                    r_phase_done, w_phase_done_nxt;

  logic [1:0] w_arb_last;
  logic [1:0] w_winner;
  logic       w_valid;
  logic       w_other;

  // Re-arbitration at the end of ALL_RED must already see the served approach as last.
  assign w_arb_last = (r_state == ST_ALL_RED) ? r_cur : r_last;
  assign w_other    = |(req & ~onehot(r_cur));

  rr_arbiter u_arb (
    .i_req        (req),
    .i_last       (w_arb_last),
    .i_preempt    (preempt),
    .i_preempt_id (preempt_id),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cur        <= 2'd0;
      r_last       <= 2'd3;
      r_timer      <= '0;
      r_grant      <= '0;
      r_yellow     <= '0;
      r_all_red    <= 1'b1;
      r_phase_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur        <= w_cur_nxt;
      r_last       <= w_last_nxt;
      r_timer      <= w_timer_nxt;
      r_grant      <= w_grant_nxt;
      r_yellow     <= w_yellow_nxt;
      r_all_red    <= w_all_red_nxt;
      r_phase_done <= w_phase_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_last_nxt  = r_last;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt = ST_GREEN;
          w_cur_nxt   = w_winner;
        end
      end
      ST_GREEN: begin
        if (preempt) begin
          if (preempt_id != r_cur) w_state_nxt = ST_YELLOW;
        end else if (r_timer >= c_GMIN_LAST && !req[r_cur]) begin
          w_state_nxt = ST_YELLOW;
        end else if (r_timer == c_GMAX_LAST && w_other) begin
          w_state_nxt = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (r_timer == c_Y_LAST) w_state_nxt = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (r_timer == c_AR_LAST) begin
          w_last_nxt = r_cur;
          if (w_valid) begin
            w_state_nxt = ST_GREEN;
            w_cur_nxt   = w_winner;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Timer restarts on every state entry; green saturates so it can extend indefinitely.
    if (w_state_nxt != r_state || r_state == ST_IDLE) begin
      w_timer_nxt = '0;
    end else if (!(r_state == ST_GREEN && r_timer == c_GMAX_LAST)) begin
      w_timer_nxt = r_timer + TW'(1);
    end

    w_grant_nxt      = (w_state_nxt == ST_GREEN)  ? onehot(w_cur_nxt) : '0;
    w_yellow_nxt     = (w_state_nxt == ST_YELLOW) ? onehot(w_cur_nxt) : '0;
    w_all_red_nxt    = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ALL_RED);
    w_phase_done_nxt = (w_state_nxt == ST_ALL_RED) && (w_timer_nxt == c_AR_LAST);
  end

  assign grant      = r_grant;
  assign yellow     = r_yellow;
  assign all_red    = r_all_red;
  assign phase_done = r_phase_done;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Directed self-checking bench for traffic_phase_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       preempt = 1'b0;
  logic [1:0] preempt_id = 2'd0;
  logic [3:0] grant;
  logic [3:0] yellow;
  logic       all_red;
  logic       phase_done;

  int n_pass  = 0;
  int n_total = 0;

  traffic_phase_scheduler dut (
    .Clk        (Clk),
    .reset      (reset),
    .req        (req),
    .preempt    (preempt),
    .preempt_id (preempt_id),
    .grant      (grant),
    .yellow     (yellow),
    .all_red    (all_red),
    .phase_done (phase_done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] g, input logic [3:0] y,
                       input logic ar, input logic pd);
    n_total++;
    assert ({grant, yellow, all_red, phase_done} === {g, y, ar, pd}) n_pass++;
    else $error("FAIL %s observed g=%b y=%b ar=%b pd=%b expected g=%b y=%b ar=%b pd=%b",
                tag, grant, yellow, all_red, phase_done, g, y, ar, pd);
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] y,
                      input logic ar, input logic pd);
    tick();
    check(tag, g, y, ar, pd);
  endtask

  task automatic green_run(input string tag, input logic [3:0] g, input int n);
    for (int k = 0; k < n; k++) step(tag, g, 4'b0000, 1'b0, 1'b0);
  endtask

  // Yellow then all-red clearance with done pulse on the final all-red cycle.
  task automatic clear_run(input string tag, input logic [3:0] y);
    for (int k = 0; k < 4; k++) step({tag, "_yel"}, 4'b0000, y, 1'b0, 1'b0);
    step({tag, "_ar0"}, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step({tag, "_ar1"}, 4'b0000, 4'b0000, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    req        = 4'b0000;
    preempt    = 1'b0;
    preempt_id = 2'd0;
    reset      = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("reset_state", 4'b0000, 4'b0000, 1'b1, 1'b0);
    reset = 1'b0;
    step("idle_no_req", 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Lone requester keeps green indefinitely
    req = 4'b0001;
    step("lone_first", 4'b0001, 4'b0000, 1'b0, 1'b0);
    green_run("lone_hold", 4'b0001, 55);
    req = 4'b0000;
    clear_run("lone_end", 4'b0001);
    step("lone_idle", 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Two contenders: GREEN_MAX then hand over
    do_reset();
    req = 4'b0011;
    green_run("pair_a", 4'b0001, 14);
    clear_run("pair_a", 4'b0001);
    green_run("pair_b", 4'b0010, 14);
    clear_run("pair_b", 4'b0010);
    step("pair_c", 4'b0001, 4'b0000, 1'b0, 1'b0);

    // Short pulse: exactly GREEN_MIN green, then back to IDLE
    do_reset();
    req = 4'b0001;
    step("pulse_g0", 4'b0001, 4'b0000, 1'b0, 1'b0);
    step("pulse_g1", 4'b0001, 4'b0000, 1'b0, 1'b0);
    req = 4'b0000;
    green_run("pulse_g", 4'b0001, 2);
    clear_run("pulse", 4'b0001);
    step("pulse_idle0", 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("pulse_idle1", 4'b0000, 4'b0000, 1'b1, 1'b0);

    // All four requesting: strict rotation
    do_reset();
    req = 4'b1111;
    green_run("rr0", 4'b0001, 14);
    clear_run("rr0", 4'b0001);
    green_run("rr1", 4'b0010, 14);
    clear_run("rr1", 4'b0010);
    green_run("rr2", 4'b0100, 14);
    clear_run("rr2", 4'b0100);
    green_run("rr3", 4'b1000, 14);
    clear_run("rr3", 4'b1000);
    green_run("rr4", 4'b0001, 3);

    // Preempt to another approach aborts green below minimum
    do_reset();
    req = 4'b0011;
    step("pre_g0", 4'b0001, 4'b0000, 1'b0, 1'b0);
    preempt    = 1'b1;
    preempt_id = 2'd2;
    clear_run("pre_abort", 4'b0001);
    step("pre_win", 4'b0100, 4'b0000, 1'b0, 1'b0);
    // Preempt on the current approach holds green past GREEN_MAX
    green_run("pre_hold", 4'b0100, 20);
    preempt = 1'b0;
    step("pre_rel_yel", 4'b0000, 4'b0100, 1'b0, 1'b0);
    step("pre_rel_yel2", 4'b0000, 4'b0100, 1'b0, 1'b0);

    // Asynchronous reset in the middle of yellow
    reset = 1'b1;
    #1;
    check("async_reset", 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    check("reset_held", 4'b0000, 4'b0000, 1'b1, 1'b0);
    reset = 1'b0;
    req   = 4'b0010;
    step("post_reset_grant", 4'b0010, 4'b0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Intersection phase scheduler that shares the single "right of way" resource among four approach requesters (e.g. main road, side road, pedestrian crossing, turn lane). It arbitrates round-robin with an emergency preempt and sequences each granted approach through GREEN, YELLOW and ALL_RED intervals using an internal phase timer. It sits above the per-approach lamp drivers, replacing fixed two-road sequencing once more than two approaches compete.

## Interface

- GREEN_MIN, 4: minimum green length, cycles (>=1)
- GREEN_MAX, 14: maximum green length when another approach waits, cycles (>= GREEN_MIN)
- YELLOW_T, 4: yellow length, cycles (>=1)
- ALLRED_T, 2: all-red clearance length, cycles (>=1)

- Clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- req  in  4  per-approach request level, bit i = approach i
- preempt  in  1  emergency preempt level
- preempt_id  in  2  approach index favoured by preempt
- grant  out  4  one-hot green; 0 when no green
- yellow  out  4  one-hot yellow; 0 otherwise
- all_red  out  1  high in IDLE and ALL_RED
- phase_done  out  1  one-cycle pulse on the last ALL_RED cycle

## Operation

- States: IDLE, GREEN, YELLOW, ALL_RED. Registers: state, cur (2b), last (2b), timer.
- Reset values: state=IDLE, grant=0, yellow=0, all_red=1, phase_done=0, cur=0, last=3, timer=0.
- Winner selection: if preempt, winner=preempt_id (regardless of req); else first set bit of req searching last+1, last+2, ... wrapping mod 4.
- IDLE: if preempt or any req -> GREEN, cur=winner, timer=0; else stay.
- GREEN (grant[cur]=1): timer increments each cycle, saturating at GREEN_MAX-1. Let other = any req bit except cur.
  - preempt with preempt_id != cur -> YELLOW immediately, minimum ignored.
  - preempt with preempt_id == cur -> stay; GREEN_MAX not applied.
  - timer >= GREEN_MIN-1 and req[cur]=0 -> YELLOW.
  - timer == GREEN_MAX-1 and other -> YELLOW.
  - otherwise stay (green extends indefinitely when alone).
- YELLOW (yellow[cur]=1): YELLOW_T cycles, then ALL_RED; timer reset on every state entry.
- ALL_RED: ALLRED_T cycles; on the last cycle phase_done=1, last=cur, then re-arbitrate from new last: any req or preempt -> GREEN with winner, else IDLE.
- Requests are not latched; a req dropped before arbitration is lost. req changes during YELLOW/ALL_RED have no effect until arbitration.
- Preempt during YELLOW/ALL_RED does not shorten them.
- Winner may equal the just-served approach only when no other request is pending (or by preempt).

## Timing

- All outputs registered; decode from next-state, so outputs change on the same edge as state.
- Request latency: req rising sampled at edge k in IDLE -> grant visible after edge k.
- Green length: exactly GREEN_MIN cycles when req[cur] already low; GREEN_MAX cycles under contention.
- Preempt abort: preempt sampled at edge k in GREEN -> yellow after edge k.
- Timer width: $clog2(max of the four parameters)+1; no wrap.
- reset asserted mid-phase: all lamps to reset values asynchronously; grant resumes only via IDLE arbitration after release.

## Structure

- Shared package traffic_pkg: state enum, default timing constants, NUM_APPROACH=4.
- Sub-module rr_arbiter: combinational round-robin picker (req, last, preempt, preempt_id -> winner, valid); reused by future lane schedulers.
- Top holds FSM, timer and output registers.

## Test plan

- Reset, req=0001 held -> grant=0001 one cycle after release; stays green 50+ cycles; yellow never asserted.
- req=0011 held -> grant=0001 14 cycles, yellow=0001 4, all_red 2 with phase_done on last, then grant=0010 14 cycles.
- req=0001 pulsed 2 cycles -> grant 4 cycles, yellow 4, all_red 2, IDLE with all_red=1.
- req=1111 held -> grant order 0001,0010,0100,1000,0001, each 14 green cycles.
- grant=0001, req=0011, preempt=1 id=2 at green cycle 1 -> yellow=0001 next cycle, after 4+2 cycles grant=0100 despite req[1].
- reset asserted during yellow -> yellow=0, grant=0, all_red=1 before next Clk edge; after release req=0010 -> grant=0010 next cycle.
